axis_udp_packetizer: RTL and testbench
======================================

# axis_udp_packetizer

Frames a continuous 32-bit AXI-Stream word stream from user logic into bounded UDP payload packets. It sits directly upstream of the `eth_udp_arp` transmit slave port, in the `aclk` domain. It asserts `tlast` at whichever comes first: the user's own `tlast`, a word-count limit, or an idle timeout. Each word is held for one slot so that `tlast` can be attached retroactively when the stream goes idle.

## Interface
- `MAX_WORDS`, 368: payload words per packet (1..368; 368 words × 4 B = 1472 B UDP maximum).
- `TIMEOUT_CYCLES`, 1024: idle `aclk` cycles before a held word is flushed as last (≥2).
- `aclk` in 1: system clock; all logic is on its rising edge.
- `aresetn` in 1: asynchronous, active-low reset.
- `s_axis_tdata` in 32: user payload word.
- `s_axis_tvalid` in 1: user word valid.
- `s_axis_tlast` in 1: user-forced end of packet.
- `s_axis_tready` out 1: block accepts the word.
- `m_axis_tdata` out 32: word to `eth_udp_arp` `s_axis_tdata`.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tlast` out 1: last word of packet.
- `m_axis_tready` in 1: downstream ready.
- `pkt_count` out 16: packets completed on `m_axis` (wraps).
- `flush_count` out 16: packets terminated by timeout (wraps).

## Operation
- Two registers:
  - hold reg (`hold_data`, `hold_last`, `hold_vld`)
  - output reg (drives `m_axis_*`).
- The output reg is free when `!m_axis_tvalid || m_axis_tready`.
- States:
  - EMPTY (`hold_vld` = 0).
  - HOLD: hold reg holds a non-terminal word.
  - TERM: hold reg holds a terminal word, `hold_last` = 1.
- `s_axis_tready`:
  - EMPTY: 1.
  - HOLD: output reg free.
  - TERM: 0.
- A word is terminal when `s_axis_tlast` = 1 or `word_cnt` == `MAX_WORDS`-1.
- Accept in EMPTY: word goes to the hold reg; next state is TERM if terminal, else HOLD.
- Accept in HOLD:
  - The held word moves to the output reg with `tlast` = 0.
  - The new word goes to the hold reg.
  - Next state is TERM if the new word is terminal, else HOLD.
- TERM, when the output reg is free: the held word moves to the output reg with `tlast` = 1; next state EMPTY.
- `word_cnt`:
  - Increments on each accept.
  - Clears to 0 on accepting a terminal word and on a timeout flush.
  - Never exceeds `MAX_WORDS`-1.
- `pkt_count` increments on each `m_axis` handshake with `tlast` = 1.
- Timeout (macro only):
  - `idle_cnt` increments each HOLD cycle without an accept and clears on any accept or state exit.
  - At `idle_cnt` ≥ `TIMEOUT_CYCLES`-1 with the output reg free: the held word moves out with `tlast` = 1, `flush_count`++, `word_cnt` := 0, next state EMPTY.
  - `idle_cnt` saturates while the output reg is busy.
- Simultaneous accept and timeout: the accept wins and no flush occurs. Accept requires the same output-free condition.
- Reset, including mid-packet:
  - Every register clears: state EMPTY, all counters 0.
  - `m_axis_tvalid`/`m_axis_tlast`/`m_axis_tdata` = 0.
  - `s_axis_tready` = 1 after release.
  - Partial packets are discarded; no `tlast` is emitted for them.

## Timing
- Non-terminal word N appears on `m_axis` the cycle after word N+1 is accepted.
- Terminal word accepted at cycle k appears at k+2 when the output is free.
- A flushed word appears `TIMEOUT_CYCLES`+1 cycles after its accept.
- Sustained throughput is 1 word/cycle while `m_axis_tready` = 1. A terminal word costs one bubble on `s_axis`.
- `m_axis_tdata`/`m_axis_tlast` hold stable while `m_axis_tvalid` && !`m_axis_tready`.
- All outputs are registered; no combinational path from `m_axis_tready` to `m_axis_*`. `s_axis_tready` may depend combinationally on `m_axis_tready`.

## Configuration
- `PACKETIZER_TIMEOUT_EN` defined: idle timeout flush as specified; `flush_count` counts flushes.
- Not defined: no timer logic. A held non-terminal word waits indefinitely for its successor. `flush_count` is tied to 0 and `TIMEOUT_CYCLES` is ignored.

## Structure
- Shared package `eth_pkt_pkg`:
  - `UDP_MAX_PAYLOAD_WORDS` = 368
  - state enum `pktz_state_t` {EMPTY, HOLD, TERM}
  - `PKT_CNT_W` = 16
- One natural sub-module, `pktz_idle_timer`: the saturating idle counter with a clear input and an expiry output. It is instantiated only under `PACKETIZER_TIMEOUT_EN`.

## Test plan
- `MAX_WORDS`=4, `m_axis_tready`=1, 10 words 0x0..0x9 back-to-back → packets {0-3},{4-7}, then `tlast` on word 0x3 and 0x7. Words 0x8/0x9 flush after the timeout; `pkt_count`=3, `flush_count`=1.
- User `s_axis_tlast` on the 2nd word (0xA5, 0x5A) → `m_axis` carries 0xA5 (`tlast`=0), 0x5A (`tlast`=1); `word_cnt` restarts at 0.
- `TIMEOUT_CYCLES`=16, single word 0xDEADBEEF → `m_axis_tvalid` with `tlast`=1 exactly 17 cycles after the accept; `flush_count`=1.
- `m_axis_tready` toggling 1/0 on a 20-word stream → no loss, duplication or reordering; data stable during stalls; `s_axis_tready` drops in TERM.
- `aresetn` pulsed low after 3 of 4 words → `m_axis_tvalid`=0 immediately. The next 4 words form a clean packet; `pkt_count` counts from 0.
- Macro undefined, one word, then 5000 idle cycles → no output. A second word then releases the first with `tlast`=0.

Source files
------------

// File: rtl/eth_pkt_pkg.sv
// eth_pkt_pkg: shared constants and types for the UDP packetizer.
// No ports; imported by axis_udp_packetizer and pktz_idle_timer.
package eth_pkt_pkg;

  localparam int UDP_MAX_PAYLOAD_WORDS = 368;
  localparam int PKT_CNT_W             = 16;

  typedef enum logic [1:0] {
    EMPTY,
    HOLD,
    TERM
  } pktz_state_t;

endpackage

// File: rtl/pktz_idle_timer.sv
// pktz_idle_timer: saturating idle counter for the packetizer flush.
// Ports: i_clk, i_rst_n, i_clr, i_inc in; o_expired out.
module pktz_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // Holds at LIM until cleared, so expiry persists
  // while the output register is busy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && r_cnt != LIM) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LIM);

endmodule

// File: rtl/axis_udp_packetizer.sv
// axis_udp_packetizer: frames a 32-bit AXI-Stream into bounded UDP
// payload packets. Ends a packet on user tlast, on MAX_WORDS, or
// (with PACKETIZER_TIMEOUT_EN defined) on an idle timeout flush.
// Ports: aclk, aresetn; s_axis_{tdata,tvalid,tlast,tready};
// m_axis_{tdata,tvalid,tlast,tready}; pkt_count, flush_count.
module axis_udp_packetizer
  import eth_pkt_pkg::*;
#(
  parameter int MAX_WORDS      = UDP_MAX_PAYLOAD_WORDS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [31:0]          s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [31:0]          m_axis_tdata,
  output logic                 m_axis_tvalid,
  output logic                 m_axis_tlast,
  input  logic                 m_axis_tready,
  output logic [PKT_CNT_W-1:0] pkt_count,
  output logic [PKT_CNT_W-1:0] flush_count
);

  if (MAX_WORDS < 1 || MAX_WORDS > UDP_MAX_PAYLOAD_WORDS)
  begin : g_bad_max
    $error("MAX_WORDS out of range");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_to
    $error("TIMEOUT_CYCLES must be >= 2");
  end

  localparam int WCW = $clog2(MAX_WORDS + 1);
  localparam logic [WCW-1:0] LAST_IDX = WCW'(MAX_WORDS - 1);

  pktz_state_t          r_state;
  logic [31:0]          r_hold_data;
  logic                 r_hold_last;
  logic [WCW-1:0]       r_word_cnt;
  logic                 r_m_valid;
  logic                 r_m_last;
  logic [31:0]          r_m_data;
  logic [PKT_CNT_W-1:0] r_pkt_cnt;

  logic w_out_free;
  logic w_s_ready;
  logic w_accept;
  logic w_term;
  logic w_flush;
  logic w_load;
  logic w_load_last;

  assign w_out_free = !r_m_valid || m_axis_tready;

  always_comb begin
    w_s_ready = 1'b0;
    unique case (r_state)
      EMPTY:   w_s_ready = 1'b1;
      HOLD:    w_s_ready = w_out_free;
      TERM:    w_s_ready = 1'b0;
      default: w_s_ready = 1'b0;
    endcase
  end

  assign w_accept = s_axis_tvalid && w_s_ready;
  assign w_term   = s_axis_tlast || (r_word_cnt == LAST_IDX);

  // Held word leaves when displaced by a new one,
  // when it is terminal, or when it is flushed.
  assign w_load = (r_state == HOLD && w_accept)
               || (r_state == TERM && w_out_free)
               || w_flush;

  // Only terminal or flushed words carry tlast out.
  assign w_load_last = r_hold_last || w_flush;

`ifdef PACKETIZER_TIMEOUT_EN
  logic                 w_expired;
  logic [PKT_CNT_W-1:0] r_flush_cnt;

  pktz_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (aclk),
    .i_rst_n  (aresetn),
    .i_clr    (w_accept || r_state != HOLD),
    .i_inc    (r_state == HOLD),
    .o_expired(w_expired)
  );

  // An accept in the same cycle wins over the flush.
  assign w_flush = (r_state == HOLD) && w_expired
                && w_out_free && !w_accept;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_flush_cnt <= '0;
    end else if (w_flush) begin
      r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign flush_count = r_flush_cnt;
`else
  assign w_flush     = 1'b0;
  assign flush_count = '0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= EMPTY;
      r_hold_data <= '0;
      r_hold_last <= 1'b0;
      r_word_cnt  <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_m_data    <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      if (r_m_valid && m_axis_tready) begin
        r_m_valid <= 1'b0;
        if (r_m_last) r_pkt_cnt <= r_pkt_cnt + 1'b1;
      end
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= r_hold_data;
        r_m_last  <= w_load_last;
      end
      if (w_accept) begin
        r_hold_data <= s_axis_tdata;
        r_hold_last <= w_term;
        r_word_cnt  <= w_term ? '0 : r_word_cnt + 1'b1;
        r_state     <= w_term ? TERM : HOLD;
      end else if (w_load) begin
        r_hold_last <= 1'b0;
        r_state     <= EMPTY;
        if (w_flush) r_word_cnt <= '0;
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_m_data;
  assign m_axis_tvalid = r_m_valid;
  assign m_axis_tlast  = r_m_last;
  assign pkt_count     = r_pkt_cnt;

endmodule

// File: tb/tb_axis_udp_packetizer.sv
// tb_axis_udp_packetizer: scoreboard bench for axis_udp_packetizer.
// Model works per word: terminal on tlast, count limit or flush.
module tb_axis_udp_packetizer;

  localparam int MAXW = 4;
  localparam int TO   = 16;
  localparam int LONG = TO + 6;
`ifdef PACKETIZER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        aclk;
  logic        aresetn;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready;
  logic [15:0] pkt_count;
  logic [15:0] flush_count;

  axis_udp_packetizer #(
    .MAX_WORDS     (MAXW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tlast (s_tlast),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tlast (m_tlast),
    .m_axis_tready(m_tready),
    .pkt_count    (pkt_count),
    .flush_count  (flush_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   mcnt;
  int   exp_pkt;
  int   exp_flush;
  bit   mon_en;
  bit   rnd_rdy;
  int   lows;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", n, a, e);
    end
  endtask

  task automatic fail_now(input string n);
    checks++;
    failures++;
    $display("FAIL %s bound expired", n);
  endtask

  // Expected behaviour per word, from the packet rules only.
  function automatic bit model_push(input logic [31:0] d,
                                    input bit ul, input bit lng);
    bit   term;
    bit   fl;
    exp_t e;
    term = ul || (mcnt == MAXW - 1);
    fl   = lng && TO_EN && !term;
    e.d  = d;
    e.l  = term || fl;
    sb.push_back(e);
    if (e.l) exp_pkt++;
    if (fl) exp_flush++;
    mcnt = (term || fl) ? 0 : mcnt + 1;
    return term;
  endfunction

  task automatic next_cycle();
    @(negedge aclk);
    if (!rnd_rdy || lows >= 2) begin
      m_tready = 1'b1;
      lows = 0;
    end else begin
      m_tready = 1'($urandom_range(0, 1));
      lows = m_tready ? 0 : lows + 1;
    end
  endtask

  task automatic send(input logic [31:0] d, input bit ul,
                      input bit lng, input int gap);
    bit term;
    bit save;
    int n;
    term = model_push(d, ul, lng);
    s_tdata  = d;
    s_tlast  = ul;
    s_tvalid = 1'b1;
    n = 0;
    #1;
    while (!s_tready && n < 100) begin
      next_cycle();
      #1;
      n++;
    end
    if (!s_tready) fail_now("accept_wait");
    next_cycle();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    save = rnd_rdy;
    if (lng) begin
      rnd_rdy  = 1'b0;
      m_tready = 1'b1;
      lows     = 0;
    end
    if (term) begin
      #1;
      chk("tready_in_term", 32'(s_tready), 32'd0);
    end
    repeat (gap) next_cycle();
    rnd_rdy = save;
  endtask

  task automatic do_reset();
    mon_en   = 1'b0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    aresetn  = 1'b0;
    #1;
    chk("rst_m_valid", 32'(m_tvalid), 32'd0);
    chk("rst_m_last", 32'(m_tlast), 32'd0);
    chk("rst_m_data", m_tdata, 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_flush_count", 32'(flush_count), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    sb.delete();
    mcnt      = 0;
    exp_pkt   = 0;
    exp_flush = 0;
    m_tready  = 1'b1;
    rnd_rdy   = 1'b0;
    lows      = 0;
    #1;
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    mon_en = 1'b1;
  endtask

  task automatic drain_check();
    int n;
    rnd_rdy  = 1'b0;
    m_tready = 1'b1;
    n = 0;
    while (sb.size() > 0 && n < 200) begin
      next_cycle();
      n++;
    end
    if (sb.size() > 0) fail_now("drain");
    repeat (2) next_cycle();
    #1;
    chk("pkt_count", 32'(pkt_count), 32'(exp_pkt));
    chk("flush_count", 32'(flush_count), 32'(exp_flush));
  endtask

  // Monitor: pops on every m_axis handshake, checks stall stability.
  initial begin
    logic        ps;
    logic [31:0] pd;
    logic        pl;
    exp_t        e;
    ps = 1'b0;
    pd = '0;
    pl = 1'b0;
    forever begin
      @(negedge aclk);
      #2;
      if (!mon_en || !aresetn) begin
        ps = 1'b0;
      end else begin
        if (ps) begin
          chk("stall_valid", 32'(m_tvalid), 32'd1);
          chk("stall_data", m_tdata, pd);
          chk("stall_last", 32'(m_tlast), 32'(pl));
        end
        if (m_tvalid && m_tready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_out data=%h required=none",
                     m_tdata);
          end else begin
            e = sb.pop_front();
            chk("out_data", m_tdata, e.d);
            chk("out_last", 32'(m_tlast), 32'(e.l));
          end
        end
        ps = m_tvalid && !m_tready;
        pd = m_tdata;
        pl = m_tlast;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int seen;
    bit ul;
    bit lng;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rnd_rdy  = 1'b0;
    lows     = 0;
    aresetn  = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;
    mcnt = 0;
    exp_pkt = 0;
    exp_flush = 0;
    #1;
    do_reset();

    // Ten back-to-back words, last one left idle.
    for (int i = 0; i < 10; i++)
      send(32'(i), 1'b0, i == 9, (i == 9) ? LONG : 0);
`ifdef PACKETIZER_TIMEOUT_EN
    drain_check();
    chk("plan_pkt_count", 32'(pkt_count), 32'd3);
    chk("plan_flush_count", 32'(flush_count), 32'd1);
`else
    send(32'h10, 1'b1, 1'b0, 0);
    drain_check();
`endif

    // User tlast on the 2nd word, then count restarts.
    do_reset();
    send(32'hA5, 1'b0, 1'b0, 0);
    send(32'h5A, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++)
      send(32'h100 + 32'(i), 1'b0, 1'b0, 0);
    drain_check();

    do_reset();
`ifdef PACKETIZER_TIMEOUT_EN
    // Flush latency of a lone word.
    send(32'hDEADBEEF, 1'b0, 1'b1, 0);
    j = 1;
    for (int k = 0; k < 40; k++) begin
      #2;
      if (m_tvalid) break;
      next_cycle();
      j++;
    end
    chk("flush_latency", 32'(j), 32'd17);
    chk("flush_tlast", 32'(m_tlast), 32'd1);
    chk("flush_cnt_now", 32'(flush_count), 32'd1);
    drain_check();
`else
    // Without the timer a lone word waits for its successor.
    send(32'hDEADBEEF, 1'b0, 1'b1, 0);
    seen = 0;
    for (int k = 0; k < 5000; k++) begin
      next_cycle();
      #2;
      if (m_tvalid) seen++;
    end
    chk("idle_no_output", 32'(seen), 32'd0);
    send(32'h12345678, 1'b1, 1'b0, 0);
    drain_check();
`endif

    // Random stream with m_axis_tready toggling.
    do_reset();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ul  = ($urandom_range(0, 7) == 0) || (i == 59);
      lng = ($urandom_range(0, 9) == 0) && (i != 59);
      send($urandom, ul, lng,
           lng ? LONG : int'($urandom_range(0, 2)));
    end
    drain_check();

    // Reset in the middle of a packet.
    do_reset();
    for (int i = 0; i < 3; i++)
      send(32'h200 + 32'(i), 1'b0, 1'b0, 0);
    do_reset();
    for (int i = 0; i < 4; i++)
      send(32'h300 + 32'(i), 1'b0, 1'b0, 0);
    drain_check();
    chk("post_reset_pkt", 32'(pkt_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
